// File: rtl/bridge_pkg.sv
// ============================================================================
// Module   : bridge_pkg
// Purpose  : Shared definitions for the SRAM / MMIO bridge: FSM state
//            encoding, MMIO register offsets and the default MMIO window tag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bridge_pkg;

  // FSM state encoding (explicit width).
  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SETUP  = 3'd1;
  localparam state_t ST_ACCESS = 3'd2;
  localparam state_t ST_DONE   = 3'd3;
  localparam state_t ST_MMIO   = 3'd4;
  // Only reachable when SRAM_WRITE_BACK_TURNAROUND_EN is defined.
  localparam state_t ST_TURN   = 3'd5;

  // MMIO register offsets within the window (addr[27:0]).
  localparam logic [27:0] LED_OFS = 28'h000_0000;
  localparam logic [27:0] DPY_OFS = 28'h000_0004;

  // Default value of addr[31:28] that selects the MMIO window.
  localparam logic [3:0] MMIO_TAG_DEFAULT = 4'hB;

  // True when a byte address falls inside the MMIO window.
  function automatic logic is_mmio(input logic [31:0] addr, input logic [3:0] tag);
    return (addr[31:28] == tag);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_wait_counter.sv
// ============================================================================
// Module   : sram_wait_counter
// Purpose  : Loadable 4-bit down-counter with a zero flag; times the strobe
//            phase of an SRAM cycle.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            load_i        - load load_val_i (has priority over dec_i)
//            load_val_i[3:0] - value to load
//            dec_i         - decrement by one (saturates at zero)
//            zero_o        - count is zero
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == 4'd0);

endmodule

`default_nettype wire

// File: rtl/sram_mmio_bridge.sv
// ============================================================================
// Module   : sram_mmio_bridge
// Purpose  : Converts a CPU request/acknowledge port into timed asynchronous
//            SRAM cycles (programmable wait states, byte lanes) and decodes a
//            small MMIO window holding the LED and seven-segment registers.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            req_i/we_i/addr_i/be_i/wdata_i - CPU request (held until ack_o)
//            rdata_o, ack_o           - read data, one-cycle completion pulse
//            ram_addr_o, ram_data_io  - SRAM word address, data bus
//            ram_be_n_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o - SRAM controls
//            led_o, dpy0_o, dpy1_o    - MMIO register outputs
// Config   : `define SRAM_WRITE_BACK_TURNAROUND_EN inserts a TURN cycle
//            (chip deselected, bus released) after every SRAM write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_mmio_bridge
  import bridge_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 20,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [3:0]  MMIO_TAG    = MMIO_TAG_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [31:0]         addr_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ack_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  inout  wire  [DATA_W-1:0]   ram_data_io,
  output logic [DATA_W/8-1:0] ram_be_n_o,
  output logic                ram_ce_n_o,
  output logic                ram_oe_n_o,
  output logic                ram_we_n_o,
  output logic [15:0]         led_o,
  output logic [3:0]          dpy0_o,
  output logic [3:0]          dpy1_o
);

  localparam int BE_W = DATA_W / 8;

  // Counter preload: ACCESS lasts until the counter reaches zero, so loading
  // WAIT_CYCLES-1 yields exactly WAIT_CYCLES strobe cycles.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic                we_q,    we_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [BE_W-1:0]     be_q,    be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [15:0]         led_q,   led_d;
  logic [3:0]          dpy0_q,  dpy0_d;
  logic [3:0]          dpy1_q,  dpy1_d;

  logic                cnt_load;
  logic                cnt_dec;
  logic                cnt_zero;
  logic                sram_active;
  logic                bus_drive;
  logic [27:0]         mmio_ofs;

  assign mmio_ofs = addr_i[27:0];

  sram_wait_counter u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (WAIT_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    led_d    = led_q;
    dpy0_d   = dpy0_q;
    dpy1_d   = dpy1_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          be_d    = be_i;
          wdata_d = wdata_i;
          if (is_mmio(addr_i, MMIO_TAG)) begin
            // MMIO registers update (or read data is captured) at the latch
            // edge so everything is settled in the following ack cycle.
            // The SRAM address is left alone to keep the SRAM pins quiet.
            state_d = ST_MMIO;
            if (we_i) begin
              if (mmio_ofs == LED_OFS) begin
                if (be_i[0]) led_d[7:0]  = wdata_i[7:0];
                if (be_i[1]) led_d[15:8] = wdata_i[15:8];
              end else if ((mmio_ofs == DPY_OFS) && be_i[0]) begin
                dpy0_d = wdata_i[3:0];
                dpy1_d = wdata_i[7:4];
              end
            end else begin
              rdata_d = '0;
              if (mmio_ofs == LED_OFS) begin
                rdata_d[15:0] = led_q;
              end else if (mmio_ofs == DPY_OFS) begin
                rdata_d[7:0] = {dpy1_q, dpy0_q};
              end
            end
          end else begin
            state_d = ST_SETUP;
            addr_d  = addr_i[ADDR_W+1:2];
          end
        end
      end

      ST_SETUP: begin
        state_d  = ST_ACCESS;
        cnt_load = 1'b1;
      end

      ST_ACCESS: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = ram_data_io;
          end
        end
      end

      ST_DONE: begin
`ifdef SRAM_WRITE_BACK_TURNAROUND_EN
        state_d = we_q ? ST_TURN : ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end

      ST_MMIO: state_d = ST_IDLE;
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      led_q   <= 16'h0000;
      dpy0_q  <= 4'h0;
      dpy1_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      led_q   <= led_d;
      dpy0_q  <= dpy0_d;
      dpy1_q  <= dpy1_d;
    end
  end

  // --------------------------------------------------------------------------
  // Pin decode: strobes are pure functions of the registered state, so a
  // reset returns every pin to idle on the following cycle.
  // --------------------------------------------------------------------------
  assign sram_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS) ||
                       (state_q == ST_DONE);
  assign bus_drive   = sram_active && we_q;

  assign ram_ce_n_o  = !sram_active;
  assign ram_oe_n_o  = !((state_q == ST_ACCESS) && !we_q);
  assign ram_we_n_o  = !((state_q == ST_ACCESS) &&  we_q);
  assign ram_be_n_o  = sram_active ? (we_q ? ~be_q : '0) : '1;
  assign ram_addr_o  = addr_q;
  assign ram_data_io = bus_drive ? wdata_q : {DATA_W{1'bz}};

  assign ack_o   = (state_q == ST_DONE) || (state_q == ST_MMIO);
  assign rdata_o = rdata_q;
  assign led_o   = led_q;
  assign dpy0_o  = dpy0_q;
  assign dpy1_o  = dpy1_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_mmio_bridge.sv
// ============================================================================
// Module   : tb_sram_mmio_bridge
// Purpose  : Self-checking bench for sram_mmio_bridge: directed scenarios plus
//            randomized SRAM/MMIO traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_mmio_bridge;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 20;
  localparam int WAIT_CYCLES = 2;
  localparam int BE_W        = DATA_W / 8;
  localparam int MAX_LAT     = 40;
`ifdef SRAM_WRITE_BACK_TURNAROUND_EN
  localparam int TURN_EN = 1;
`else
  localparam int TURN_EN = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic [ADDR_W-1:0] ram_addr;
  wire  [DATA_W-1:0] ram_data;
  logic [BE_W-1:0]   ram_be_n;
  logic              ce_n, oe_n, we_n;
  logic [15:0]       led;
  logic [3:0]        dpy0, dpy1;

  always #5 clk = ~clk;

  sram_mmio_bridge #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES),
    .MMIO_TAG    (4'hB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .be_i        (be),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .ack_o       (ack),
    .ram_addr_o  (ram_addr),
    .ram_data_io (ram_data),
    .ram_be_n_o  (ram_be_n),
    .ram_ce_n_o  (ce_n),
    .ram_oe_n_o  (oe_n),
    .ram_we_n_o  (we_n),
    .led_o       (led),
    .dpy0_o      (dpy0),
    .dpy1_o      (dpy1)
  );

  // Behavioural asynchronous SRAM (16 words).
  logic [DATA_W-1:0] mem [0:15];
  assign ram_data = (!ce_n && !oe_n) ? mem[ram_addr[3:0]] : {DATA_W{1'bz}};

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      for (int i = 0; i < BE_W; i++) begin
        if (!ram_be_n[i]) mem[ram_addr[3:0]][8*i +: 8] <= ram_data[8*i +: 8];
      end
    end
  end

  // Transaction-level expectations.
  logic [DATA_W-1:0] exp_mem [0:15];
  logic [15:0]       exp_led;
  logic [3:0]        exp_dpy0, exp_dpy1;
  logic [DATA_W-1:0] exp_rdata;
  bit                prev_sram_wr;
  bit                req_held;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One CPU transaction, entered and left at a negedge.
  task automatic run_txn(input bit t_we, input logic [31:0] t_addr,
                         input logic [BE_W-1:0] t_be, input logic [DATA_W-1:0] t_wdata,
                         input bit keep_req);
    bit              mm;
    bit              done;
    bit              overlap;
    int              lat, exp_lat, oe_cnt, we_cnt, ce_cnt;
    int              word;
    logic [BE_W-1:0] exp_ben;
    logic [27:0]     ofs;

    mm      = (t_addr[31:28] == 4'hB);
    word    = int'(t_addr[5:2]);
    ofs     = t_addr[27:0];
    exp_lat = (mm ? 1 : WAIT_CYCLES + 2) + (req_held ? 1 : 0) +
              ((TURN_EN != 0 && prev_sram_wr) ? 1 : 0);

    req = 1'b1; we = t_we; addr = t_addr; be = t_be; wdata = t_wdata;
    lat = 0; done = 1'b0; overlap = 1'b0; oe_cnt = 0; we_cnt = 0; ce_cnt = 0;
    while (!done && lat < MAX_LAT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!ce_n) ce_cnt++;
      if (!oe_n) oe_cnt++;
      if (!we_n) begin
        we_cnt++;
        check_eq("wr_bus", ram_data, t_wdata);
      end
      if (!oe_n && !we_n) overlap = 1'b1;
      if (ack) done = 1'b1;
    end

    // Model update
    if (mm) begin
      if (t_we) begin
        if (ofs == 28'h0) begin
          if (t_be[0]) exp_led[7:0]  = t_wdata[7:0];
          if (t_be[1]) exp_led[15:8] = t_wdata[15:8];
        end else if (ofs == 28'h4 && t_be[0]) begin
          exp_dpy0 = t_wdata[3:0];
          exp_dpy1 = t_wdata[7:4];
        end
      end else begin
        if (ofs == 28'h0)      exp_rdata = {16'h0, exp_led};
        else if (ofs == 28'h4) exp_rdata = {24'h0, exp_dpy1, exp_dpy0};
        else                   exp_rdata = '0;
      end
    end else begin
      if (t_we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (t_be[i]) exp_mem[word][8*i +: 8] = t_wdata[8*i +: 8];
        end
      end else begin
        exp_rdata = exp_mem[word];
      end
    end

    check_eq("ack_latency", lat, exp_lat);
    check_eq("oe_low_cycles", oe_cnt, (!mm && !t_we) ? WAIT_CYCLES : 0);
    check_eq("we_low_cycles", we_cnt, (!mm && t_we) ? WAIT_CYCLES : 0);
    check_eq("ce_low_cycles", ce_cnt, mm ? 0 : WAIT_CYCLES + 2);
    check_eq("oe_we_overlap", overlap, 0);
    check_eq("rdata", rdata, exp_rdata);
    check_eq("led", led, exp_led);
    check_eq("dpy", {dpy1, dpy0}, {exp_dpy1, exp_dpy0});
    if (!mm) begin
      exp_ben = t_we ? ~t_be : '0;
      check_eq("ram_addr", ram_addr, t_addr[ADDR_W+1:2]);
      check_eq("ram_be_n", ram_be_n, exp_ben);
      if (t_we) check_eq("sram_word", mem[word], exp_mem[word]);
    end

    prev_sram_wr = !mm && t_we;
    req_held     = keep_req;
    if (!keep_req) begin
      req = 1'b0;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] sram_addr(input int word);
    logic [5:0] hi;
    logic [1:0] lo;
    hi = 6'($urandom);
    lo = 2'($urandom);
    return {4'h0, hi, 16'h0, 4'(word), lo};
  endfunction

  task automatic check_idle_after_reset();
    check_eq("rst_ce_n", ce_n, 1);
    check_eq("rst_oe_n", oe_n, 1);
    check_eq("rst_we_n", we_n, 1);
    check_eq("rst_be_n", ram_be_n, {BE_W{1'b1}});
    check_eq("rst_ack", ack, 0);
    check_eq("rst_ram_addr", ram_addr, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_led", led, 0);
    check_eq("rst_dpy", {dpy1, dpy0}, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      mem[i] = v;
      exp_mem[i] = v;
    end
    mem[4] = 32'hDEAD_BEEF;
    exp_mem[4] = 32'hDEAD_BEEF;
    exp_led = '0; exp_dpy0 = '0; exp_dpy1 = '0; exp_rdata = '0;
    prev_sram_wr = 1'b0; req_held = 1'b0;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_after_reset();
    rst = 1'b0;
    @(negedge clk);

    // Directed scenarios
    run_txn(1'b0, 32'h0000_0010, 4'hF, '0, 1'b0);
    run_txn(1'b1, 32'h0000_0010, 4'b0101, 32'h1234_5678, 1'b0);
    run_txn(1'b0, 32'h0000_0010, 4'hF, '0, 1'b0);
    run_txn(1'b1, 32'hB000_0000, 4'b0011, 32'h0000_A5A5, 1'b0);
    run_txn(1'b1, 32'hB000_0004, 4'b0001, 32'h0000_003C, 1'b0);
    run_txn(1'b0, 32'hB000_0004, 4'hF, '0, 1'b0);
    run_txn(1'b0, 32'hB000_0000, 4'hF, '0, 1'b0);
    run_txn(1'b0, 32'hB000_0008, 4'hF, '0, 1'b0);
    run_txn(1'b1, 32'hB000_000C, 4'hF, 32'hFFFF_FFFF, 1'b0);
    // Back-to-back read then write then read with req held throughout
    run_txn(1'b0, 32'h0000_0020, 4'hF, '0, 1'b1);
    run_txn(1'b1, 32'h0000_0024, 4'hF, 32'hCAFE_F00D, 1'b1);
    run_txn(1'b0, 32'h0000_0024, 4'hF, '0, 1'b0);
    // Write with no byte enables: full cycle, memory untouched
    run_txn(1'b1, 32'h0000_0008, 4'h0, 32'h5555_AAAA, 1'b0);
    run_txn(1'b0, 32'h0000_0008, 4'hF, '0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      bit               r_mm, r_we, r_keep;
      logic [31:0]      r_addr;
      logic [27:0]      r_ofs;
      r_mm   = ($urandom_range(0, 3) == 0);
      r_we   = $urandom_range(0, 1) == 1;
      r_keep = ($urandom_range(0, 3) == 0);
      r_ofs  = 28'(4 * $urandom_range(0, 3));
      r_addr = r_mm ? {4'hB, r_ofs} : sram_addr($urandom_range(0, 14));
      run_txn(r_we, r_addr, 4'($urandom), $urandom, r_keep);
    end
    if (req_held) begin
      req = 1'b0;
      repeat (3) @(negedge clk);
      req_held = 1'b0;
      prev_sram_wr = 1'b0;
    end

    // Reset during the ACCESS phase of a write (word 15 is reserved for this)
    run_txn(1'b1, 32'hB000_0000, 4'b0011, 32'h0000_1E1E, 1'b0);
    req = 1'b1; we = 1'b1; addr = 32'h0000_003C; be = 4'hF; wdata = 32'h0BAD_0BAD;
    @(posedge clk);   // latch
    @(posedge clk);   // SETUP -> ACCESS
    @(negedge clk);
    check_eq("pre_rst_we_n", we_n, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_after_reset();
    rst = 1'b0; req = 1'b0;
    exp_led = '0; exp_dpy0 = '0; exp_dpy1 = '0; exp_rdata = '0;
    prev_sram_wr = 1'b0; req_held = 1'b0;
    @(negedge clk);

    // Recovery after reset
    run_txn(1'b0, 32'h0000_0010, 4'hF, '0, 1'b0);
    run_txn(1'b1, 32'hB000_0004, 4'b0001, 32'h0000_0091, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
